// File: rtl/ace_pkg.sv
// Shared ACE snoop definitions: CR bit positions, cache state-update
// opcodes, AC snoop opcodes and the default snoop channel structs.
package ace_pkg;

  // CR response bit positions
  localparam int unsigned CrDt  = 0;  // DataTransfer
  localparam int unsigned CrErr = 1;  // Error
  localparam int unsigned CrPd  = 2;  // PassDirty
  localparam int unsigned CrIs  = 3;  // IsShared
  localparam int unsigned CrWu  = 4;  // WasUnique

  // State update requested from the local cache after a snoop hit
  typedef enum logic [1:0] {
    UPD_NONE    = 2'd0,
    UPD_SHARED  = 2'd1,
    UPD_CLEAN   = 2'd2,
    UPD_INVALID = 2'd3
  } upd_op_e;

  // AC snoop opcodes shared with the CCU
  localparam logic [3:0] SNP_READ_ONCE       = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED     = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN      = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD        = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE     = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED    = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID   = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID    = 4'b1101;
  localparam logic [3:0] SNP_DVM_COMPLETE    = 4'b1110;
  localparam logic [3:0] SNP_DVM_MESSAGE     = 4'b1111;

  // Default channel payloads for a 64-bit address / 64-bit data snoop bus
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

  // True for the snoops this responder answers with a cache lookup
  function automatic logic snoop_supported(input logic [3:0] snoop);
    case (snoop)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD,
      SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID,
      SNP_MAKE_INVALID: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ace_snoop_cd_serializer.sv
// Holds one captured cache line and streams it onto CD, lowest beat first,
// advancing only on a cd_valid & cd_ready handshake. done pulses with the
// handshake of the last beat.
module ace_snoop_cd_serializer
  import ace_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LineWidth-1:0] line,
  input  logic                 cd_ready,
  output logic                 cd_valid,
  output logic [DataWidth-1:0] cd_data,
  output logic                 cd_last,
  output logic                 done
);

  localparam int unsigned NoBeats  = LineWidth / DataWidth;
  localparam int unsigned CntWidth = (NoBeats > 1) ? $clog2(NoBeats) : 1;
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NoBeats - 1);

  logic                 busy_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [LineWidth-1:0] line_q;
  logic                 beat_hs;

  assign cd_valid = busy_q;
  assign cd_last  = busy_q && (cnt_q == LastBeat);
  assign cd_data  = busy_q ? line_q[32'(cnt_q) * DataWidth +: DataWidth] : '0;
  assign beat_hs  = busy_q & cd_ready;
  assign done     = beat_hs & cd_last;

  // Burst control: start arms the burst, each handshake advances the beat
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (beat_hs) begin
      if (cd_last) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  // Line capture at lookup result time
  // NOTE: the line register is pure datapath and is left without reset; its
  // contents are only visible while busy_q is set.
  always_ff @(posedge clk) begin
    if (start) line_q <= line;
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop slave: accepts one AC snoop, looks up the private cache, returns
// CR and, when DataTransfer is set, streams the line on CD.
// Optional build macro ACE_SNOOP_RESP_ERR_EN: unsupported snoops answer with
// the Error bit instead of an all-zero response.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned LineWidth    = 512,
  parameter type         snoop_req_t  = ace_pkg::snoop_req_t,
  parameter type         snoop_resp_t = ace_pkg::snoop_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  snoop_req_t           snoop_req_i,
  output snoop_resp_t          snoop_resp_o,
  output logic                 lookup_req_o,
  output logic [AddrWidth-1:0] lookup_addr_o,
  input  logic                 lookup_gnt_i,
  input  logic                 lookup_valid_i,
  input  logic                 lookup_hit_i,
  input  logic                 lookup_dirty_i,
  input  logic                 lookup_shared_i,
  input  logic [LineWidth-1:0] lookup_data_i,
  output logic                 upd_valid_o,
  output logic [1:0]           upd_op_o
);

  localparam int unsigned OffsetBits = $clog2(LineWidth / 8);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

`ifdef ACE_SNOOP_RESP_ERR_EN
  localparam logic [4:0] UnsupResp = 5'b00010;
`else
  localparam logic [4:0] UnsupResp = 5'b00000;
`endif

  logic [1:0]                    state_q, state_d;
  logic                          armed_q;
  logic [AddrWidth-1:OffsetBits] addr_q;
  logic [3:0]                    snoop_q;
  logic [4:0]                    cr_resp_q;
  logic                          cr_done_q, cd_done_q;

  logic       ac_ready, ac_hs, result, cr_valid, cr_hs;
  logic       cr_complete, cd_complete;
  logic       dt, pd, is_sh;
  logic [4:0] hit_resp;
  upd_op_e    hit_op;
  logic       ser_start, ser_done, cd_valid, cd_last;
  logic [DataWidth-1:0] cd_data;
  logic       addr_unused;

  // Line-offset bits are never forwarded to the cache
  assign addr_unused = ^snoop_req_i.ac.addr[OffsetBits-1:0];

  assign ac_ready     = armed_q && (state_q == StIdle);
  assign ac_hs        = ac_ready && snoop_req_i.ac_valid;
  assign result       = (state_q == StWait) && lookup_valid_i;
  assign cr_valid     = (state_q == StResp) && !cr_done_q;
  assign cr_hs        = cr_valid && snoop_req_i.cr_ready;
  assign cr_complete  = cr_done_q || cr_hs;
  assign cd_complete  = cd_done_q || ser_done;
  assign ser_start    = result && lookup_hit_i && hit_resp[CrDt];

  assign lookup_req_o  = (state_q == StLookup);
  assign lookup_addr_o = {addr_q, {OffsetBits{1'b0}}};
  assign upd_valid_o   = result && lookup_hit_i;
  assign upd_op_o      = upd_valid_o ? hit_op : UPD_NONE;

  // Hit response and state update from the captured opcode and line state
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    dt     = 1'b0;
    pd     = 1'b0;
    is_sh  = 1'b0;
    hit_op = UPD_NONE;
    case (snoop_q)
      SNP_READ_ONCE: begin
        dt = 1'b1; is_sh = 1'b1;
      end
      SNP_READ_SHARED, SNP_READ_NSD: begin
        dt = 1'b1; is_sh = 1'b1; pd = lookup_dirty_i; hit_op = UPD_SHARED;
      end
      SNP_READ_CLEAN: begin
        dt = 1'b1; is_sh = 1'b1;
      end
      SNP_READ_UNIQUE: begin
        dt = 1'b1; pd = lookup_dirty_i; hit_op = UPD_INVALID;
      end
      SNP_CLEAN_SHARED: begin
        dt = lookup_dirty_i; is_sh = 1'b1; pd = lookup_dirty_i; hit_op = UPD_CLEAN;
      end
      SNP_CLEAN_INVALID: begin
        dt = lookup_dirty_i; pd = lookup_dirty_i; hit_op = UPD_INVALID;
      end
      SNP_MAKE_INVALID: begin
        hit_op = UPD_INVALID;
      end
      default: ;
    endcase
    hit_resp        = '0;
    hit_resp[CrDt]  = dt;
    hit_resp[CrPd]  = pd;
    hit_resp[CrIs]  = is_sh;
    hit_resp[CrWu]  = !lookup_shared_i;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (ac_hs) state_d = snoop_supported(snoop_req_i.ac.snoop) ? StLookup : StResp;
      StLookup: if (lookup_gnt_i) state_d = StWait;
      StWait:   if (lookup_valid_i) state_d = StResp;
      StResp:   if (cr_complete && cd_complete) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM, captured snoop, CR payload and per-channel completion flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      addr_q    <= '0;
      snoop_q   <= '0;
      cr_resp_q <= '0;
      cr_done_q <= 1'b0;
      cd_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (ac_hs) begin
        addr_q  <= snoop_req_i.ac.addr[AddrWidth-1:OffsetBits];
        snoop_q <= snoop_req_i.ac.snoop;
        if (!snoop_supported(snoop_req_i.ac.snoop)) begin
          cr_resp_q <= UnsupResp;
          cr_done_q <= 1'b0;
          cd_done_q <= 1'b1;
        end
      end
      if (result) begin
        cr_resp_q <= lookup_hit_i ? hit_resp : 5'b00000;
        cr_done_q <= 1'b0;
        cd_done_q <= !(lookup_hit_i && hit_resp[CrDt]);
      end
      if (state_q == StResp) begin
        if (cr_hs)    cr_done_q <= 1'b1;
        if (ser_done) cd_done_q <= 1'b1;
      end
    end
  end

  ace_snoop_cd_serializer #(
    .DataWidth (DataWidth),
    .LineWidth (LineWidth)
  ) u_cd_serializer (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .start    (ser_start),
    .line     (lookup_data_i),
    .cd_ready (snoop_req_i.cd_ready),
    .cd_valid (cd_valid),
    .cd_data  (cd_data),
    .cd_last  (cd_last),
    .done     (ser_done)
  );

  // Response channel assembly; CR payload is zero while CR is idle
  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready;
    snoop_resp_o.cr_valid = cr_valid;
    snoop_resp_o.cr_resp  = cr_valid ? cr_resp_q : 5'b00000;
    snoop_resp_o.cd_valid = cd_valid;
    snoop_resp_o.cd.data  = cd_data;
    snoop_resp_o.cd.last  = cd_last;
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: a directed vector table,
// hand-written corner sequences and randomized snoops checked against a
// rule-level response model.
module tb_ace_snoop_responder;
  import ace_pkg::*;

  localparam int NB = 8;

`ifdef ACE_SNOOP_RESP_ERR_EN
  localparam logic [4:0] UNSUP = 5'b00010;
`else
  localparam logic [4:0] UNSUP = 5'b00000;
`endif

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  snoop_req_t  req;
  snoop_resp_t resp;
  logic        lookup_req, lookup_gnt, lookup_valid;
  logic        lookup_hit, lookup_dirty, lookup_shared;
  logic [63:0]  lookup_addr;
  logic [511:0] lookup_data;
  logic        upd_valid;
  logic [1:0]  upd_op;

  ace_snoop_responder dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .snoop_req_i    (req),
    .snoop_resp_o   (resp),
    .lookup_req_o   (lookup_req),
    .lookup_addr_o  (lookup_addr),
    .lookup_gnt_i   (lookup_gnt),
    .lookup_valid_i (lookup_valid),
    .lookup_hit_i   (lookup_hit),
    .lookup_dirty_i (lookup_dirty),
    .lookup_shared_i(lookup_shared),
    .lookup_data_i  (lookup_data),
    .upd_valid_o    (upd_valid),
    .upd_op_o       (upd_op)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observations of one snoop transaction
  bit          o_finished;
  int          o_cr_cnt, o_upd_cnt, o_lookups, o_addr_err, o_stab_err;
  int          o_ac_cyc, o_cr_cyc, o_crhs_cyc, o_lastbeat_cyc, o_ready_cyc;
  logic [4:0]  o_cr_resp;
  logic [1:0]  o_upd_op;
  logic [63:0] beats[$];
  logic        lasts[$];

  typedef struct {
    logic [3:0] snp;
    logic       hit, dirty, shared;
    logic [4:0] resp;
    bit         lookup;
    bit         upd;
    logic [1:0] op;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Response rules expressed per snoop class rather than per state
  function automatic void model(input logic [3:0] snp, input logic hit, input logic dirty,
                                input logic shared, output logic [4:0] r, output bit lookup,
                                output bit upd, output logic [1:0] op);
    bit sup;
    int dt, pd, is_sh, wu;
    sup = snp inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD,
                      SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID};
    lookup = sup; upd = 0; op = 2'd0; r = 5'd0;
    if (!sup) begin
      r = UNSUP;
      return;
    end
    if (!hit) return;
    if (snp inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD, SNP_READ_UNIQUE})
      dt = 1;
    else if (snp inside {SNP_CLEAN_SHARED, SNP_CLEAN_INVALID})
      dt = int'(dirty);
    else
      dt = 0;
    pd = (snp inside {SNP_READ_SHARED, SNP_READ_NSD, SNP_READ_UNIQUE,
                      SNP_CLEAN_SHARED, SNP_CLEAN_INVALID}) ? int'(dirty) : 0;
    is_sh = (snp inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_NSD,
                         SNP_READ_CLEAN, SNP_CLEAN_SHARED}) ? 1 : 0;
    wu = shared ? 0 : 1;
    r = 5'(dt + 4 * pd + 8 * is_sh + 16 * wu);
    upd = 1;
    if (snp inside {SNP_READ_SHARED, SNP_READ_NSD}) op = 2'd1;
    else if (snp == SNP_CLEAN_SHARED)               op = 2'd2;
    else if (snp inside {SNP_READ_ONCE, SNP_READ_CLEAN}) op = 2'd0;
    else                                            op = 2'd3;
  endfunction

  // Acts as CCU and cache for one snoop; inputs driven at negedge, outputs sampled 1 ns later
  task automatic run_snoop(input logic [3:0] snp, input logic [63:0] addr, input logic hit,
                           input logic dirty, input logic shared, input logic [511:0] line,
                           input int gnt_dly, input int val_dly, input int cr_dly, input bit cd_rnd);
    int cyc = 0, lreq_cyc = 0, crv_cyc = 0, valid_at = -1;
    bit ac_done = 0, cr_held = 0, cd_held = 0;
    logic [4:0]  cr_hold = '0;
    logic [63:0] cd_hold = '0;
    logic        cd_last_hold = 1'b0;
    logic [63:0] exp_addr;
    exp_addr = addr & ~64'h3F;
    beats.delete(); lasts.delete();
    o_finished = 0; o_cr_cnt = 0; o_upd_cnt = 0; o_lookups = 0; o_addr_err = 0; o_stab_err = 0;
    o_ac_cyc = -1; o_cr_cyc = -1; o_crhs_cyc = -1; o_lastbeat_cyc = -1; o_ready_cyc = -1;
    o_cr_resp = '0; o_upd_op = '0;
    while (!o_finished && cyc < 300) begin
      @(negedge clk);
      req.ac_valid    = !ac_done;
      req.ac.addr     = addr;
      req.ac.snoop    = snp;
      lookup_gnt      = 1'b0;
      if (lookup_req) begin
        lreq_cyc++;
        lookup_gnt = (lreq_cyc > gnt_dly);
      end
      lookup_valid  = (cyc == valid_at);
      lookup_hit    = lookup_valid ? hit : 1'b0;
      lookup_dirty  = lookup_valid ? dirty : 1'b0;
      lookup_shared = lookup_valid ? shared : 1'b0;
      lookup_data   = lookup_valid ? line : rand_line();
      req.cr_ready  = resp.cr_valid && (crv_cyc >= cr_dly);
      req.cd_ready  = cd_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (lookup_req) begin
        o_lookups++;
        if (lookup_addr !== exp_addr) o_addr_err++;
        if (lookup_gnt) valid_at = cyc + val_dly;
      end
      if (upd_valid) begin
        o_upd_cnt++;
        o_upd_op = upd_op;
      end
      if (req.ac_valid && resp.ac_ready) begin
        ac_done = 1;
        o_ac_cyc = cyc;
      end else if (ac_done && resp.ac_ready) begin
        o_ready_cyc = cyc;
        o_finished = 1;
      end
      if (resp.cr_valid) begin
        if (o_cr_cyc < 0) o_cr_cyc = cyc;
        if (cr_held && resp.cr_resp !== cr_hold) o_stab_err++;
        cr_hold = resp.cr_resp;
        cr_held = 1;
        crv_cyc++;
        if (req.cr_ready) begin
          o_cr_cnt++;
          o_cr_resp = resp.cr_resp;
          o_crhs_cyc = cyc;
          cr_held = 0;
        end
      end else if (cr_held) o_stab_err++;
      if (resp.cd_valid) begin
        if (cd_held && (resp.cd.data !== cd_hold || resp.cd.last !== cd_last_hold)) o_stab_err++;
        if (req.cd_ready) begin
          beats.push_back(resp.cd.data);
          lasts.push_back(resp.cd.last);
          if (resp.cd.last) o_lastbeat_cyc = cyc;
          cd_held = 0;
        end else begin
          cd_held = 1;
          cd_hold = resp.cd.data;
          cd_last_hold = resp.cd.last;
        end
      end else if (cd_held) o_stab_err++;
      cyc++;
    end
  endtask

  task automatic check_txn(input string tag, input logic [4:0] er, input bit el, input bit eu,
                           input logic [1:0] eop, input logic [511:0] line);
    int nb;
    int done_cyc;
    logic [511:0] sh;
    nb = er[0] ? NB : 0;
    check({tag, ".finished"}, 64'(o_finished), 64'd1);
    check({tag, ".cr_count"}, 64'(o_cr_cnt), 64'd1);
    check({tag, ".cr_resp"}, 64'(o_cr_resp), 64'(er));
    check({tag, ".lookup"}, 64'(o_lookups > 0), 64'(el));
    check({tag, ".addr_err"}, 64'(o_addr_err), 64'd0);
    check({tag, ".upd_count"}, 64'(o_upd_cnt), 64'(eu));
    if (eu) check({tag, ".upd_op"}, 64'(o_upd_op), 64'(eop));
    check({tag, ".stable_err"}, 64'(o_stab_err), 64'd0);
    check({tag, ".beat_count"}, 64'(beats.size()), 64'(nb));
    sh = line;
    for (int k = 0; k < nb && k < beats.size(); k++) begin
      check($sformatf("%s.beat%0d", tag, k), beats[k], sh[63:0]);
      check($sformatf("%s.last%0d", tag, k), 64'(lasts[k]), 64'(k == NB - 1));
      sh = sh >> 64;
    end
    done_cyc = (o_lastbeat_cyc > o_crhs_cyc) ? o_lastbeat_cyc : o_crhs_cyc;
    check({tag, ".ac_ready_return"}, 64'(o_ready_cyc), 64'(done_cyc + 1));
  endtask

  initial begin
    logic [511:0] line;
    logic [63:0]  addr;
    logic [4:0]   er;
    bit           el, eu;
    logic [1:0]   eop;
    logic [3:0]   snp;
    logic         h, d, s;

    tbl[0]  = '{SNP_READ_SHARED,   1'b1, 1'b1, 1'b0, 5'b11101, 1, 1, 2'd1};
    tbl[1]  = '{SNP_READ_UNIQUE,   1'b0, 1'b1, 1'b0, 5'b00000, 1, 0, 2'd0};
    tbl[2]  = '{SNP_CLEAN_SHARED,  1'b1, 1'b0, 1'b1, 5'b01000, 1, 1, 2'd2};
    tbl[3]  = '{SNP_READ_ONCE,     1'b1, 1'b1, 1'b1, 5'b01001, 1, 1, 2'd0};
    tbl[4]  = '{SNP_READ_CLEAN,    1'b1, 1'b1, 1'b0, 5'b11001, 1, 1, 2'd0};
    tbl[5]  = '{SNP_READ_NSD,      1'b1, 1'b0, 1'b1, 5'b01001, 1, 1, 2'd1};
    tbl[6]  = '{SNP_READ_UNIQUE,   1'b1, 1'b1, 1'b0, 5'b10101, 1, 1, 2'd3};
    tbl[7]  = '{SNP_CLEAN_INVALID, 1'b1, 1'b1, 1'b1, 5'b00101, 1, 1, 2'd3};
    tbl[8]  = '{SNP_CLEAN_INVALID, 1'b1, 1'b0, 1'b0, 5'b10000, 1, 1, 2'd3};
    tbl[9]  = '{SNP_MAKE_INVALID,  1'b1, 1'b1, 1'b0, 5'b10000, 1, 1, 2'd3};
    tbl[10] = '{SNP_CLEAN_SHARED,  1'b1, 1'b1, 1'b0, 5'b11101, 1, 1, 2'd2};
    tbl[11] = '{SNP_DVM_MESSAGE,   1'b1, 1'b1, 1'b0, UNSUP,    0, 0, 2'd0};

    req = '0;
    lookup_gnt = 0; lookup_valid = 0; lookup_hit = 0; lookup_dirty = 0; lookup_shared = 0;
    lookup_data = '0;
    rst_ni = 1'b0;

    // Reset state
    #1;
    check("rst.ac_ready", 64'(resp.ac_ready), 64'd0);
    check("rst.cr_valid", 64'(resp.cr_valid), 64'd0);
    check("rst.cd_valid", 64'(resp.cd_valid), 64'd0);
    check("rst.lookup_req", 64'(lookup_req), 64'd0);
    check("rst.upd_valid", 64'(upd_valid), 64'd0);
    check("rst.lookup_addr", lookup_addr, 64'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst.ac_ready", 64'(resp.ac_ready), 64'd1);

    // Directed table, minimum-latency handshakes
    for (int i = 0; i < 12; i++) begin
      line = rand_line();
      addr = {$urandom, $urandom};
      run_snoop(tbl[i].snp, addr, tbl[i].hit, tbl[i].dirty, tbl[i].shared, line, 0, 1, 0, 0);
      check_txn($sformatf("tbl%0d", i), tbl[i].resp, tbl[i].lookup, tbl[i].upd, tbl[i].op, line);
      check($sformatf("tbl%0d.cr_latency", i), 64'(o_cr_cyc - o_ac_cyc), tbl[i].lookup ? 64'd3 : 64'd1);
    end

    // CR held off for 10 cycles while the whole CD burst completes
    line = rand_line();
    run_snoop(SNP_READ_SHARED, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b0, line, 0, 1, 10, 0);
    check_txn("cr_stall", 5'b11101, 1, 1, 2'd1, line);
    check("cr_stall.wait", 64'(o_crhs_cyc - o_cr_cyc), 64'd10);
    check("cr_stall.cd_first", 64'(o_lastbeat_cyc < o_crhs_cyc), 64'd1);

    // Lookup result strobe while idle is ignored
    @(negedge clk);
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_dirty = 1'b1;
    #1;
    check("idle_valid.upd", 64'(upd_valid), 64'd0);
    @(negedge clk);
    lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_dirty = 1'b0;
    #1;
    check("idle_valid.ac_ready", 64'(resp.ac_ready), 64'd1);
    check("idle_valid.cr_valid", 64'(resp.cr_valid), 64'd0);

    // Reset asserted while waiting for the lookup result
    @(negedge clk);
    req.ac_valid = 1'b1; req.ac.snoop = SNP_READ_UNIQUE; req.ac.addr = 64'hFFFF_0000_0000_1040;
    req.cr_ready = 1'b0; req.cd_ready = 1'b0;
    @(negedge clk);
    req.ac_valid = 1'b0;
    #1;
    check("rst_wait.lookup_req", 64'(lookup_req), 64'd1);
    lookup_gnt = 1'b1;
    @(negedge clk);
    lookup_gnt = 1'b0;
    rst_ni = 1'b0;
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_dirty = 1'b1; lookup_data = rand_line();
    #1;
    check("rst_wait.upd_valid", 64'(upd_valid), 64'd0);
    check("rst_wait.lookup_req0", 64'(lookup_req), 64'd0);
    check("rst_wait.resp_zero", 64'(resp != '0), 64'd0);
    @(posedge clk);
    #1;
    check("rst_wait.edge_cr_valid", 64'(resp.cr_valid), 64'd0);
    check("rst_wait.edge_upd", 64'(upd_valid), 64'd0);
    check("rst_wait.edge_addr", lookup_addr, 64'd0);
    @(negedge clk);
    lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_dirty = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wait.recover_ready", 64'(resp.ac_ready), 64'd1);
    check("rst_wait.recover_cr", 64'(resp.cr_valid), 64'd0);

    // Randomized snoops with random stalls, checked against the rule model
    for (int n = 0; n < 40; n++) begin
      snp  = 4'($urandom_range(0, 15));
      h    = 1'($urandom_range(0, 1));
      d    = 1'($urandom_range(0, 1));
      s    = 1'($urandom_range(0, 1));
      line = rand_line();
      addr = {$urandom, $urandom};
      model(snp, h, d, s, er, el, eu, eop);
      run_snoop(snp, addr, h, d, s, line, $urandom_range(0, 3), $urandom_range(1, 3),
                $urandom_range(0, 4), 1);
      check_txn($sformatf("rnd%0d", n), er, el, eu, eop, line);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ace_snoop_responder.md
# ace_snoop_responder

Cache-side ACE snoop slave that accepts one snoop on the AC channel and looks up the local cache through a simple request/grant lookup port. It returns the coherence response on CR and, when the response carries data, the full cache line on CD as a burst of beats. It sits between one `SNOOP_BUS` master port of the CCU and a private data cache, and is the responder counterpart of the CCU snoop path.

## Interface
- `AddrWidth`, 64: AC address width.
- `DataWidth`, 64: CD data width; must divide `LineWidth`.
- `LineWidth`, 512: cache line width in bits; `NoBeats = LineWidth/DataWidth`, a power of two, at least 1.
- `snoop_req_t`, logic: `SNOOP_TYPEDEF_REQ_T` struct carrying `ac`, `ac_valid`, `cr_ready`, `cd_ready`.
- `snoop_resp_t`, logic: `SNOOP_TYPEDEF_RESP_T` struct carrying `ac_ready`, `cr_valid`, `cr_resp`, `cd_valid`, `cd.data`, `cd.last`.

Ports:
- `clk_i` in 1: the block's only clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `snoop_req_i` in struct: AC request plus CR/CD ready signals from the CCU.
- `snoop_resp_o` out struct: `ac_ready`, CR and CD toward the CCU.
- `lookup_req_o` out 1: lookup request to the cache.
- `lookup_addr_o` out AddrWidth: snoop address with the low `$clog2(LineWidth/8)` bits zeroed.
- `lookup_gnt_i` in 1: lookup accepted.
- `lookup_valid_i` in 1: one-cycle result strobe, at least 1 cycle after the grant.
- `lookup_hit_i`, `lookup_dirty_i`, `lookup_shared_i` in 1 each: line state, qualified by `lookup_valid_i`.
- `lookup_data_i` in LineWidth: line data, qualified by `lookup_valid_i`.
- `upd_valid_o` out 1: one-cycle state-update strobe.
- `upd_op_o` out 2: the state update to apply; NONE=0, SHARED=1, CLEAN=2, INVALID=3.

## Operation
- FSM states are IDLE, LOOKUP, WAIT and RESP.
- **IDLE**
  - `ac_ready` = 1 in IDLE only.
  - On an AC handshake, capture `acaddr` and `acsnoop`.
  - Supported snoop → LOOKUP.
  - Unsupported snoop (DVM or any other code) → RESP with no lookup.
- **LOOKUP**
  - Hold `lookup_req_o` = 1 with a stable address until `lookup_gnt_i`, then → WAIT.
- **WAIT**
  - On `lookup_valid_i`, compute and register `cr_resp`, register the line, then → RESP.
  - `upd_valid_o` pulses in the same cycle with `upd_op_o`, issued only on a hit; the line is already captured, so the cache may apply it immediately.
- **Response table on a hit** (CR bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique; WasUnique = !shared on every hit):
  - ReadOnce: DT=1, IS=1, PD=0; upd NONE.
  - ReadShared, ReadNotSharedDirty: DT=1, IS=1, PD=dirty; upd SHARED, which leaves the line clean.
  - ReadClean: DT=1, IS=1, PD=0; upd NONE, so the line keeps its dirty state.
  - ReadUnique: DT=1, IS=0, PD=dirty; upd INVALID.
  - CleanShared: DT=dirty, IS=1, PD=dirty; upd CLEAN.
  - CleanInvalid: DT=dirty, IS=0, PD=dirty; upd INVALID.
  - MakeInvalid: DT=0, PD=0; upd INVALID.
- **Miss**: `cr_resp` = 0, no CD, no update.
- **RESP**
  - `cr_valid` = 1 until the CR handshake.
  - If DT=1, CD beats are driven concurrently: beat k = `line[k*DataWidth +: DataWidth]`, lowest beat first.
  - `cd.last` is set on beat `NoBeats-1`.
  - The beat counter advances only on a `cd_valid & cd_ready` handshake.
  - Return to IDLE only when both CR and the last CD beat have completed, in whichever order they finish.

## Timing
- Reset values: all outputs 0, FSM in IDLE, beat counter 0, done flags cleared.
- Minimum latency:
  - AC handshake, then `lookup_req_o` on the next cycle.
  - With grant in that cycle and result 1 cycle later, `cr_valid` rises 3 cycles after the AC handshake.
  - An unsupported snoop gives `cr_valid` on the cycle after the AC handshake.
- Handshake rules:
  - Valid signals never drop and payloads never change before their ready.
  - CR and CD are independent; a stall on one never blocks the other.
- The beat counter wraps to 0 after the last beat.
- A new AC is accepted no earlier than the cycle after RESP completes; there is one outstanding snoop at a time.
- `lookup_valid_i` outside WAIT is ignored.
- Reset mid-transaction aborts everything: outputs drop immediately and no update is issued.

## Configuration
- `ACE_SNOOP_RESP_ERR_EN`
  - Defined: unsupported snoops return `cr_resp` = 5'b00010 (Error).
  - Undefined: unsupported snoops return 0.

## Structure
- `ace_pkg` holds:
  - the CR bit index constants;
  - the `upd_op_e` enum;
  - the snoop opcode constants that this block shares with the CCU.
- Sub-module `ace_snoop_cd_serializer`: line register, beat counter and CD handshake, with `start`/`done` signals.

## Test plan
- ReadShared hit, dirty=1, shared=0, NoBeats=8, `cd_ready` tied high → `cr_resp` = 5'b11101; 8 beats with `last` on beat 7; `upd_op` SHARED.
- Miss on ReadUnique → `cr_resp` = 0; no `cd_valid`; no `upd_valid`; `ac_ready` returns 1 cycle after the CR handshake.
- CleanShared clean hit → `cr_resp` = 5'b01000 with WasUnique set to !shared; no CD; upd CLEAN.
- `cr_ready` held low for 10 cycles while all CD beats complete → CR stays stable and the FSM leaves RESP only after `cr_ready`.
- Random `cd_ready` toggling → beats are in order and unchanged while stalled.
- DVM snoop with and without `ACE_SNOOP_RESP_ERR_EN` → 5'b00010 or 0; no lookup; `rst_ni` pulsed in WAIT → all outputs 0 at the next edge.
